// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake, flush-to-bubble and saturating stall counter.
// Latency: one cycle from accept to dout/out_valid. Build option PIPE_STAGE_ELASTIC_SKID_EN selects a two-entry skid buffer.
// Backpressure: base mode in_ready = ~out_valid | out_ready (combinational); skid mode in_ready is decoded from state only.
module pipe_stage_elastic #(
  parameter int                  NUM_BITS     = 16,
  parameter logic [NUM_BITS-1:0] BUBBLE_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] din,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] dout,
  output logic [15:0]         stall_count
);

  logic accept;
  logic take;
  logic stalled;

  assign accept  = in_valid & in_ready;
  assign take    = out_valid & out_ready;
  assign stalled = out_valid & ~out_ready;

  // Flush leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 16'd0;
    end else if (stalled && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

`ifdef PIPE_STAGE_ELASTIC_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NUM_BITS-1:0] main_q;
  logic [NUM_BITS-1:0] main_d;
  logic [NUM_BITS-1:0] skid_q;
  logic [NUM_BITS-1:0] skid_d;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_TWO);
  assign dout      = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = din;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_d = din;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = din;
          end else if (take) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (take) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VALUE;
          skid_d  = BUBBLE_VALUE;
        end
      endcase
    end
  end

`else

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= BUBBLE_VALUE;
    end else if (flush) begin
      out_valid <= 1'b0;
      dout      <= BUBBLE_VALUE;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= din;
    end else if (take) begin
      out_valid <= 1'b0;
      dout      <= BUBBLE_VALUE;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic; expectations adapt to PIPE_STAGE_ELASTIC_SKID_EN where in_ready differs.
module tb_pipe_stage_elastic;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic [15:0] stall_count;

  int checks;
  int errors;

  pipe_stage_elastic #(
    .NUM_BITS    (16),
    .BUBBLE_VALUE(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    din       = 16'h0000;
    out_ready = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_dout", dout, 16'h0000);
    check("rst_stall", stall_count, 16'h0000);
    check("rst_in_ready", {15'd0, in_ready}, 16'h0001);

    // Stream 1..8 with downstream always ready.
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din = 16'(i);
      tick();
      check("stream_dout", dout, 16'(i));
      check("stream_valid", {15'd0, out_valid}, 16'h0001);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", {15'd0, out_valid}, 16'h0000);
    check("drain_dout", dout, 16'h0000);
    check("stream_stall", stall_count, 16'h0000);

    // Fill with 0x00AB then stall five cycles.
    in_valid  = 1'b1;
    din       = 16'h00AB;
    out_ready = 1'b0;
    tick();
    check("stall_fill_dout", dout, 16'h00AB);
    check("stall_count0", stall_count, 16'h0000);
    in_valid = 1'b0;
    #1;
`ifdef PIPE_STAGE_ELASTIC_SKID_EN
    check("stall_in_ready", {15'd0, in_ready}, 16'h0001);
`else
    check("stall_in_ready", {15'd0, in_ready}, 16'h0000);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_dout_hold", dout, 16'h00AB);
    end
    check("stall_count5", stall_count, 16'h0005);
    in_valid  = 1'b1;
    din       = 16'h00CD;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {15'd0, in_ready}, 16'h0001);
    tick();
    check("release_dout", dout, 16'h00CD);
    check("release_valid", {15'd0, out_valid}, 16'h0001);
    in_valid = 1'b0;
    tick();
    check("release_drain", {15'd0, out_valid}, 16'h0000);
    check("release_stall", stall_count, 16'h0005);

    // Flush in the same cycle as accepting 0x5678.
    in_valid = 1'b1;
    din      = 16'h1234;
    tick();
    check("flush_fill", dout, 16'h1234);
    din   = 16'h5678;
    flush = 1'b1;
    tick();
    check("flush_valid", {15'd0, out_valid}, 16'h0000);
    check("flush_dout", dout, 16'h0000);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_no_5678_valid", {15'd0, out_valid}, 16'h0000);
    check("flush_no_5678_dout", dout, 16'h0000);
    check("flush_stall_kept", stall_count, 16'h0005);

    // Reset priority over flush and accept with stall_count = 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clear_stall", stall_count, 16'h0000);
    in_valid = 1'b1;
    din      = 16'h0011;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("prio_stall3", stall_count, 16'h0003);
    rst       = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    din       = 16'h0F0F;
    out_ready = 1'b1;
    tick();
    check("prio_valid", {15'd0, out_valid}, 16'h0000);
    check("prio_dout", dout, 16'h0000);
    check("prio_stall", stall_count, 16'h0000);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Ordering under backpressure: 0x0001 then 0x0002.
    in_valid  = 1'b1;
    din       = 16'h0001;
    out_ready = 1'b0;
    tick();
    check("order_first", dout, 16'h0001);
    din = 16'h0002;
    tick();
    check("order_hold", dout, 16'h0001);
    check("order_in_ready_low", {15'd0, in_ready}, 16'h0000);
    out_ready = 1'b1;
    tick();
    check("order_second", dout, 16'h0002);
    check("order_in_ready_back", {15'd0, in_ready}, 16'h0001);
    in_valid = 1'b0;
    tick();
    check("order_empty", {15'd0, out_valid}, 16'h0000);
    check("order_stall", stall_count, 16'h0001);

    // Saturation from a clean counter.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b1;
    din       = 16'h0055;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    check("sat_fffe", stall_count, 16'hFFFE);
    tick();
    check("sat_ffff", stall_count, 16'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", stall_count, 16'hFFFF);
    check("sat_dout", dout, 16'h0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
